// File: rtl/watch_time_ascii_tx_if.sv
// ============================================================================
// Module   : watch_time_ascii_tx_if
// Brief    : Byte-wide valid/ready handshake between the time formatter and
//            the UART transmitter byte input.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface watch_time_ascii_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

`default_nettype wire

// File: rtl/watch_time_ascii_tx.sv
// ============================================================================
// Module   : watch_time_ascii_tx
// Brief    : Snapshots the watch time and streams it as "HH:MM:SS[.CC][\r\n]".
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module watch_time_ascii_tx #(
   parameter int WITH_MSEC = 0,
   parameter int TERM_CRLF = 1
) (
   input  wire logic                          clk,
   input  wire logic                          rst,
   input  wire logic                          start,
   input  wire logic [4:0]                    hour,
   input  wire logic [5:0]                    min,
   input  wire logic [5:0]                    sec,
   input  wire logic [6:0]                    msec,
   watch_time_ascii_tx_if.master              tx,
   output logic                               busy,
   output logic                               done
);

   localparam int         N_BYTES  = 8 + 3 * WITH_MSEC + 2 * TERM_CRLF;
   localparam logic [3:0] LAST_IDX = 4'(N_BYTES - 1);
   localparam logic [3:0] TAIL_IDX = 4'(8 + 3 * WITH_MSEC);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [4:0] hour_q;
   logic [5:0] min_q, sec_q;
   logic [6:0] msec_q;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_valid_q, tx_valid_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       snap_load;

   // Two ASCII digits from a compare/subtract chain; out-of-range gives "--".
   function automatic logic [15:0] field_ascii(input logic [6:0] v, input logic [6:0] lim);
      logic [6:0] r;
      logic [3:0] t;
      r = v;
      t = 4'd0;
      if (v > lim) return {8'h2D, 8'h2D};
      for (int i = 0; i < 9; i++) begin
         if (r >= 7'd10) begin
            r = r - 7'd10;
            t = t + 4'd1;
         end
      end
      return {8'h30 + {4'd0, t}, 8'h30 + {1'b0, r}};
   endfunction

   // Byte 0 is produced on the start edge, before the snapshot holds the time.
   logic        from_inputs;
   logic [3:0]  sel_idx;
   logic [15:0] h_asc, m_asc, s_asc, c_asc;
   logic [7:0]  sel_byte;

   assign from_inputs = (state_q == S_IDLE);
   assign sel_idx     = from_inputs ? 4'd0 : idx_q + 4'd1;
   assign h_asc = field_ascii(from_inputs ? {2'b00, hour} : {2'b00, hour_q}, 7'd23);
   assign m_asc = field_ascii(from_inputs ? {1'b0, min}   : {1'b0, min_q},   7'd59);
   assign s_asc = field_ascii(from_inputs ? {1'b0, sec}   : {1'b0, sec_q},   7'd59);
   assign c_asc = field_ascii(from_inputs ? msec          : msec_q,          7'd99);

   always_comb begin
      sel_byte = 8'h0A;
      case (sel_idx)
         4'd0:    sel_byte = h_asc[15:8];
         4'd1:    sel_byte = h_asc[7:0];
         4'd2:    sel_byte = 8'h3A;
         4'd3:    sel_byte = m_asc[15:8];
         4'd4:    sel_byte = m_asc[7:0];
         4'd5:    sel_byte = 8'h3A;
         4'd6:    sel_byte = s_asc[15:8];
         4'd7:    sel_byte = s_asc[7:0];
         default: begin
            if (WITH_MSEC != 0 && sel_idx == 4'd8)       sel_byte = 8'h2E;
            else if (WITH_MSEC != 0 && sel_idx == 4'd9)  sel_byte = c_asc[15:8];
            else if (WITH_MSEC != 0 && sel_idx == 4'd10) sel_byte = c_asc[7:0];
            else if (sel_idx == TAIL_IDX)                sel_byte = 8'h0D;
            else                                         sel_byte = 8'h0A;
         end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      snap_load  = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            if (start) begin
               state_d    = S_SEND;
               idx_d      = 4'd0;
               tx_data_d  = sel_byte;
               tx_valid_d = 1'b1;
               busy_d     = 1'b1;
               snap_load  = 1'b1;
            end
         end
         S_SEND: begin
            if (tx_valid_q && tx.tx_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d    = S_DONE;
                  tx_data_d  = 8'h00;
                  tx_valid_d = 1'b0;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
               end else begin
                  idx_d     = idx_q + 4'd1;
                  tx_data_d = sel_byte;
               end
            end
         end
         default: begin
            state_d    = S_IDLE;
            tx_data_d  = 8'h00;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         idx_q      <= 4'd0;
         hour_q     <= 5'd0;
         min_q      <= 6'd0;
         sec_q      <= 6'd0;
         msec_q     <= 7'd0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         if (snap_load) begin
            hour_q <= hour;
            min_q  <= min;
            sec_q  <= sec;
            msec_q <= msec;
         end
      end
   end

   assign tx.tx_data  = tx_data_q;
   assign tx.tx_valid = tx_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

`default_nettype wire

// File: doc/watch_time_ascii_tx.md
# watch_time_ascii_tx

Reads the running time from the watch datapath (hour/min/sec/msec counts) and serialises it as an ASCII text frame, e.g. "12:34:56\r\n", one byte at a time to the UART transmitter over a valid/ready byte handshake. The block sits between the watch datapath outputs and the UART TX byte input. It is the readback path for the time that the watch counters produce: it snapshots the counts, converts each field to two decimal digits and streams the frame without gaps when the transmitter accepts every byte.

## Interface
Parameters:
- WITH_MSEC, default 0: 1 appends ".CC" (centiseconds from msec) after the seconds field.
- TERM_CRLF, default 1: 1 appends CR (0x0D) and LF (0x0A) to the frame.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  reset; asynchronous and active-low (0 = reset).
- start  input  1  one-cycle request to send one frame.
- hour  input  5  hour count, legal range 0..23.
- min  input  6  minute count, legal range 0..59.
- sec  input  6  second count, legal range 0..59.
- msec  input  7  centisecond count, legal range 0..99.
- tx_data  output  8  ASCII byte offered to the UART TX.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  UART TX accepts the byte this cycle.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse after the last byte of a frame is accepted.

## Operation
- States:
  - IDLE: waiting for start.
  - SEND: offering frame bytes.
  - DONE: single cycle; emits the done pulse.
- IDLE → SEND when start=1 at a clock edge.
  - At that same edge, latch hour/min/sec/msec into snapshot registers and clear the byte index to 0.
  - Input changes after the latch do not affect the frame in progress.
- Frame order: H1 H0 ':' M1 M0 ':' S1 S0, then '.' C1 C0 if WITH_MSEC=1, then 0x0D 0x0A if TERM_CRLF=1.
  - Frame length N = 8 + 3·WITH_MSEC + 2·TERM_CRLF, so N is 8, 10, 11 or 13.
- Digit conversion, per field:
  - tens = value/10, ones = value − 10·tens. Use a compare/subtract chain; no divider IP.
  - Each byte is 0x30 + digit. ':' is 0x3A and '.' is 0x2E.
- Out-of-range field (hour>23, min>59, sec>59, msec>99): both digits of that field are sent as '-' (0x2D). The other fields are unaffected.
- Handshake:
  - In SEND, tx_valid=1 and tx_data = byte[index].
  - A byte transfers in any cycle where tx_valid=1 and tx_ready=1. On a transfer, index increments.
  - While tx_valid=1 and tx_ready=0, tx_data holds stable.
  - tx_ready while tx_valid=0 is ignored.
- After byte N−1 transfers, go to DONE. In DONE: tx_valid=0, busy=0, done=1. Then return to IDLE.
- start while in SEND or DONE is ignored; it is not queued.

## Timing
- Reset values: tx_data=0x00, tx_valid=0, busy=0, done=0, state IDLE, index 0, snapshot 0.
- start latency: start sampled at edge k gives tx_valid=1 with byte 0 and busy=1 from cycle k+1.
- Throughput: with tx_ready held high, one byte per cycle with no bubbles. Bytes 0..N−1 occupy cycles k+1..k+N.
- done is high in cycle k+N+1 only. busy and tx_valid are low in that cycle.
- The earliest accepted next start is at the edge ending the cycle after done. Minimum spacing from one start to the next is N+2 cycles.
- Reset mid-frame: outputs go to their reset values asynchronously, the frame is abandoned with no done pulse, and the block is in IDLE after reset release.
- All outputs are registered. None depends combinationally on tx_ready or start.

## Test plan
- Reset: assert rst=0 mid-run, then release. Required: tx_valid=0, busy=0, done=0, tx_data=0x00, immediately and after release.
- Basic frame (WITH_MSEC=0, TERM_CRLF=1, tx_ready=1): hour=12, min=34, sec=56, one-cycle start pulse. Required: bytes 31 32 3A 33 34 3A 35 36 0D 0A on 10 consecutive cycles starting the cycle after start, then one done pulse.
- Backpressure: same frame with random tx_ready stalls, including ready low on the first and last byte. Required: the same 10 bytes in order, tx_data stable throughout every stall, done exactly once, after the final transfer.
- Snapshot and ignore: change sec to 57 and pulse start again in the middle of the frame. Required: the frame still carries "56", and no second frame is sent.
- Msec and zero fields (WITH_MSEC=1, TERM_CRLF=0): hour=0, min=0, sec=0, msec=7. Required: bytes 30 30 3A 30 30 3A 30 30 2E 30 37 (11 bytes), then done.
- Range: hour=23, min=59, sec=60. Required: 32 33 3A 35 39 3A 2D 2D 0D 0A.
